// File: rtl/x_23k640_array.sv
// Flat byte-addressed front end for an array of 23K640 SPI SRAMs sharing one SCK.
// Runs one 32-bit READ/WRITE frame at a time and pulses o_ready on completion.
module x_23k640_array #(
    parameter int unsigned NUM_CHIPS = 8,
    parameter int unsigned CLK_DIV   = 4,
    localparam int unsigned CHIP_W   = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 0,
    localparam int unsigned ADDR_W   = 13 + CHIP_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_accept,
    input  logic                 i_rd_n_wr,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [7:0]           i_wdata,
    output logic                 o_ready,
    output logic [7:0]           o_rdata,
    output logic                 o_sck,
    output logic [NUM_CHIPS-1:0] o_cs,
    output logic [NUM_CHIPS-1:0] o_so,
    input  logic [NUM_CHIPS-1:0] i_si
);
    localparam int unsigned SEL_W = (CHIP_W > 0) ? CHIP_W : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [7:0]  CMD_WRITE = 8'h02;

    generate
        if (NUM_CHIPS == 0 || NUM_CHIPS > 16 || (NUM_CHIPS & (NUM_CHIPS - 1)) != 0) begin : g_bad_chips
            $error("NUM_CHIPS must be a power of two in 1..16");
        end
        if (CLK_DIV == 0) begin : g_bad_div
            $error("CLK_DIV must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DESEL} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [30:0]      shreg;
    logic [SEL_W-1:0] chip;
    logic             rd;
    logic [7:0]       rx;

    logic [SEL_W-1:0] req_chip;
    logic [31:0]      req_frame;
    logic             half_end;

    generate
        if (CHIP_W > 0) begin : g_chip
            assign req_chip = i_addr[ADDR_W-1:13];
        end else begin : g_single
            assign req_chip = '0;
        end
    endgenerate

    assign req_frame = {i_rd_n_wr ? CMD_READ : CMD_WRITE, 3'b000, i_addr[12:0],
                        i_rd_n_wr ? 8'h00 : i_wdata};
    assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));

    function automatic logic [NUM_CHIPS-1:0] sel_mask(input logic [SEL_W-1:0] c);
        return NUM_CHIPS'(1) << c;
    endfunction

    // Frame sequencer: sck toggles every half-period, so changes on the falling edge,
    // MISO is sampled on the edge that raises sck.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            o_accept <= 1'b1;
            o_ready  <= 1'b0;
            o_rdata  <= '0;
            o_sck    <= 1'b0;
            o_cs     <= '1;
            o_so     <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            chip     <= '0;
            rd       <= 1'b0;
            rx       <= '0;
        end else begin
            o_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state    <= SHIFT;
                        o_accept <= 1'b0;
                        shreg    <= req_frame[30:0];
                        chip     <= req_chip;
                        rd       <= i_rd_n_wr;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        o_sck    <= 1'b0;
                        o_cs     <= ~sel_mask(req_chip);
                        o_so     <= req_frame[31] ? sel_mask(req_chip) : '0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        if (!o_sck) begin
                            o_sck <= 1'b1;
                            rx    <= {rx[6:0], i_si[chip]};
                        end else begin
                            o_sck <= 1'b0;
                            if (bit_cnt == 5'd31) begin
                                state <= HOLD;
                                o_so  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                shreg   <= {shreg[29:0], 1'b0};
                                o_so    <= shreg[30] ? sel_mask(chip) : '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        state   <= DESEL;
                        div_cnt <= '0;
                        o_cs    <= '1;
                        o_ready <= 1'b1;
                        o_rdata <= rd ? rx : 8'h00;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DESEL: begin
                    if (half_end) begin
                        state    <= IDLE;
                        div_cnt  <= '0;
                        o_accept <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
